// File: rtl/msg_link_pkg.sv
// msg_link_pkg: shared state encoding and character tables for the ASCII message link
package msg_link_pkg;
  typedef enum logic [1:0] {HUNT, TRACK, LOCKED} state_t;
  localparam int MSG_A_LEN = 9;
  localparam int MSG_B_LEN = 7;
  localparam logic [0:MSG_A_LEN-1][7:0] MSG_A = {8'h47, 8'h75, 8'h61, 8'h74, 8'h65, 8'h6D, 8'h61, 8'h6C, 8'h61};
  localparam logic [0:MSG_B_LEN-1][7:0] MSG_B = {8'h51, 8'h51, 8'h75, 8'h65, 8'h74, 8'h7A, 8'h61};
endpackage

// File: rtl/msg_char_rom.sv
// msg_char_rom: expected character and end-of-frame flag for a message index
module msg_char_rom
  import msg_link_pkg::*;
(
  input  logic       i_msg_sel,
  input  logic [3:0] i_idx,
  output logic [7:0] o_char,
  output logic       o_is_last
);
  always_comb begin
    o_char = i_msg_sel ? (i_idx < 4'(MSG_B_LEN) ? MSG_B[i_idx[2:0]] : 8'h00)
                       : (i_idx < 4'(MSG_A_LEN) ? MSG_A[i_idx] : 8'h00);
    o_is_last = i_idx == (i_msg_sel ? 4'(MSG_B_LEN - 1) : 4'(MSG_A_LEN - 1));
  end
endmodule

// File: rtl/msg_stream_rx.sv
// msg_stream_rx: frame aligner/lock tracker for the ASCII message byte stream
module msg_stream_rx
  import msg_link_pkg::*;
#(
  parameter int LOCK_FRAMES = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       i_data_in,
  input  logic             i_data_valid,
  input  logic [1:0]       i_select,
  output logic             o_locked,
  output logic             o_frame_ok,
  output logic [CNT_W-1:0] o_frame_cnt,
  output logic             o_err_pulse,
  output logic [7:0]       o_err_cnt,
  output logic [3:0]       o_char_idx
);
  state_t r_state, w_state_n;
  logic [3:0] r_idx, w_idx_n, r_good, w_good_n;
  logic [CNT_W-1:0] r_frame_cnt, w_frame_cnt_n;
  logic [7:0] r_err_cnt, w_err_cnt_n, w_exp, w_first;
  logic r_sel_prev, r_locked, r_frame_ok, r_err_pulse;
  logic w_sel, w_last, w_match, w_fok_n, w_ep_n;
  assign w_sel = i_select[1] ^ i_select[0];
  assign w_first = w_sel ? MSG_B[0] : MSG_A[0];
  assign w_match = i_data_in == w_exp;
  msg_char_rom u_rom (
    .i_msg_sel(w_sel),
    .i_idx    (r_idx),
    .o_char   (w_exp),
    .o_is_last(w_last)
  );
  // A select change takes priority over the byte on the same edge and discards it
  always_comb begin
    w_state_n = r_state;
    w_idx_n = r_idx;
    w_good_n = r_good;
    w_frame_cnt_n = r_frame_cnt;
    w_err_cnt_n = r_err_cnt;
    w_fok_n = 1'b0;
    w_ep_n = 1'b0;
    if (w_sel != r_sel_prev) begin
      w_state_n = HUNT;
      w_idx_n = 4'd0;
      w_good_n = 4'd0;
    end else if (i_data_valid) begin
      if (w_match && r_state == HUNT) begin
        w_state_n = TRACK;
        w_idx_n = 4'd1;
      end else if (w_match && !w_last) begin
        w_idx_n = r_idx + 4'd1;
      end else if (w_match) begin
        w_idx_n = 4'd0;
        w_fok_n = 1'b1;
        w_frame_cnt_n = r_frame_cnt + CNT_W'(r_frame_cnt != '1);
        w_good_n = r_state == TRACK ? r_good + 4'd1 : r_good;
        w_state_n = (r_state == TRACK && r_good + 4'd1 == 4'(LOCK_FRAMES)) ? LOCKED : r_state;
      end else begin
        w_good_n = 4'd0;
        w_state_n = i_data_in == w_first ? TRACK : HUNT;
        w_idx_n = i_data_in == w_first ? 4'd1 : 4'd0;
        w_ep_n = r_state == LOCKED;
        w_err_cnt_n = r_err_cnt + 8'(r_state == LOCKED && r_err_cnt != 8'hFF);
      end
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= HUNT;
      r_idx <= 4'd0;
      r_good <= 4'd0;
      r_sel_prev <= 1'b0;
      r_locked <= 1'b0;
      r_frame_ok <= 1'b0;
      r_err_pulse <= 1'b0;
      r_frame_cnt <= '0;
      r_err_cnt <= 8'd0;
    end else begin
      r_state <= w_state_n;
      r_idx <= w_idx_n;
      r_good <= w_good_n;
      r_sel_prev <= w_sel;
      r_locked <= w_state_n == LOCKED;
      r_frame_ok <= w_fok_n;
      r_err_pulse <= w_ep_n;
      r_frame_cnt <= w_frame_cnt_n;
      r_err_cnt <= w_err_cnt_n;
    end
  end
  assign o_locked = r_locked;
  assign o_frame_ok = r_frame_ok;
  assign o_err_pulse = r_err_pulse;
  assign o_frame_cnt = r_frame_cnt;
  assign o_err_cnt = r_err_cnt;
  assign o_char_idx = r_idx;
endmodule

// File: tb/tb_msg_stream_rx.sv
// tb_msg_stream_rx: directed and random stimulus against a behavioural frame model
module tb_msg_stream_rx;
  localparam int LF = 2;
  logic clk = 0, reset = 1, i_data_valid = 0;
  logic [7:0] i_data_in = 0;
  logic [1:0] i_select = 0;
  logic o_locked, o_frame_ok, o_err_pulse;
  logic [15:0] o_frame_cnt;
  logic [7:0] o_err_cnt;
  logic [3:0] o_char_idx;
  int n_chk = 0, n_fail = 0;
  logic en = 0;
  logic [7:0] ma [9] = '{8'h47, 8'h75, 8'h61, 8'h74, 8'h65, 8'h6D, 8'h61, 8'h6C, 8'h61};
  logic [7:0] mb [7] = '{8'h51, 8'h51, 8'h75, 8'h65, 8'h74, 8'h7A, 8'h61};
  int m_st, m_idx, m_good, m_fcnt, m_ecnt;
  logic m_prev, m_fok, m_ep;

  msg_stream_rx #(.LOCK_FRAMES(LF), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .i_data_in(i_data_in), .i_data_valid(i_data_valid),
    .i_select(i_select), .o_locked(o_locked), .o_frame_ok(o_frame_ok),
    .o_frame_cnt(o_frame_cnt), .o_err_pulse(o_err_pulse), .o_err_cnt(o_err_cnt),
    .o_char_idx(o_char_idx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] get(input logic s, input int i);
    if (s) return i < 7 ? mb[i] : 8'h00;
    return i < 9 ? ma[i] : 8'h00;
  endfunction

  task automatic model_reset();
    m_st = 0; m_idx = 0; m_good = 0; m_fcnt = 0; m_ecnt = 0;
    m_prev = 0; m_fok = 0; m_ep = 0;
  endtask

  // m_st: 0 hunting, 1 aligned, 2 locked
  task automatic model(input logic v, input logic [1:0] s, input logic [7:0] d);
    logic ms;
    int last;
    ms = s[1] ^ s[0];
    last = ms ? 6 : 8;
    m_fok = 0; m_ep = 0;
    if (ms != m_prev) begin
      m_st = 0; m_idx = 0; m_good = 0;
    end else if (v) begin
      if (d == get(ms, m_idx)) begin
        if (m_st == 0) begin m_st = 1; m_idx = 1; end
        else if (m_idx == last) begin
          m_idx = 0; m_fok = 1;
          if (m_fcnt < 65535) m_fcnt++;
          if (m_st == 1) begin m_good++; if (m_good == LF) m_st = 2; end
        end else m_idx++;
      end else begin
        if (m_st == 2) begin m_ep = 1; if (m_ecnt < 255) m_ecnt++; end
        m_good = 0;
        m_st = (d == get(ms, 0)) ? 1 : 0;
        m_idx = m_st;
      end
    end
    m_prev = ms;
  endtask

  always @(negedge clk) if (en && !reset) begin
    chk("locked", o_locked, m_st == 2);
    chk("frame_ok", o_frame_ok, m_fok);
    chk("err_pulse", o_err_pulse, m_ep);
    chk("frame_cnt", o_frame_cnt, m_fcnt);
    chk("err_cnt", o_err_cnt, m_ecnt);
    chk("char_idx", o_char_idx, m_idx);
  end

  task automatic cyc(input logic v, input logic [1:0] s, input logic [7:0] d);
    i_data_valid = v; i_select = s; i_data_in = d;
    @(posedge clk);
    model(v, s, d);
    #1;
  endtask

  task automatic send(input logic [1:0] s, input int from, input int to);
    for (int i = from; i <= to; i++) cyc(1, s, get(s[1] ^ s[0], i));
  endtask

  task automatic do_reset();
    reset = 1; i_data_valid = 0; i_select = 0; model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 0;
  endtask

  initial begin
    logic [1:0] rs;
    do_reset();
    en = 1;
    chk("rst_locked", o_locked, 0);
    chk("rst_cnt", o_frame_cnt, 0);
    chk("rst_idx", o_char_idx, 0);
    // lock on A
    send(2'b00, 0, 8);
    chk("A_fok9", o_frame_ok, 1);
    chk("A_unlocked9", o_locked, 0);
    send(2'b00, 0, 8);
    chk("A_locked18", o_locked, 1);
    chk("A_fcnt", o_frame_cnt, 2);
    chk("A_ecnt", o_err_cnt, 0);
    // error while locked
    send(2'b00, 0, 2);
    cyc(1, 2'b00, 8'h00);
    chk("E_pulse", o_err_pulse, 1);
    chk("E_cnt", o_err_cnt, 1);
    chk("E_locked", o_locked, 0);
    chk("E_idx", o_char_idx, 0);
    cyc(0, 2'b00, 8'h00);
    chk("E_pulse_once", o_err_pulse, 0);
    send(2'b00, 0, 8);
    send(2'b00, 0, 8);
    chk("E_relock", o_locked, 1);
    // select change while locked
    send(2'b00, 0, 2);
    cyc(1, 2'b01, 8'h47);
    chk("S_locked", o_locked, 0);
    chk("S_idx", o_char_idx, 0);
    chk("S_pulse", o_err_pulse, 0);
    chk("S_ecnt", o_err_cnt, 1);
    // message B lock, then 01->10 is not a change
    send(2'b01, 0, 6);
    send(2'b01, 0, 6);
    chk("B_locked14", o_locked, 1);
    send(2'b10, 0, 3);
    chk("B_keep_lock", o_locked, 1);
    chk("B_keep_idx", o_char_idx, 4);
    // realign and gaps
    cyc(0, 2'b00, 8'h00);
    send(2'b00, 0, 4);
    chk("R_idx5", o_char_idx, 5);
    cyc(1, 2'b00, 8'h47);
    chk("R_idx1", o_char_idx, 1);
    chk("R_noerr", o_err_pulse, 0);
    send(2'b00, 1, 3);
    repeat (3) cyc(0, 2'b00, 8'hFF);
    chk("G_idx", o_char_idx, 4);
    send(2'b00, 4, 8);
    chk("G_fok", o_frame_ok, 1);
    // random traffic
    rs = 2'b00;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 49) == 0) rs = 2'($urandom);
      cyc($urandom_range(0, 7) != 0, rs,
          $urandom_range(0, 15) == 0 ? 8'($urandom) : get(rs[1] ^ rs[0], m_idx));
    end
    // error counter saturation
    do_reset();
    for (int n = 0; n < 260; n++) begin
      send(2'b00, 0, 8);
      send(2'b00, 0, 8);
      cyc(1, 2'b00, 8'h00);
    end
    chk("SAT_ecnt", o_err_cnt, 255);
    // asynchronous reset mid-frame
    send(2'b00, 0, 3);
    #2 reset = 1;
    model_reset();
    #1;
    chk("AR_locked", o_locked, 0);
    chk("AR_fcnt", o_frame_cnt, 0);
    chk("AR_ecnt", o_err_cnt, 0);
    chk("AR_idx", o_char_idx, 0);
    chk("AR_pulses", {o_frame_ok, o_err_pulse}, 0);
    @(negedge clk) reset = 0;
    send(2'b00, 0, 8);
    chk("AR_frame", o_frame_cnt, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/msg_stream_rx.md
# msg_stream_rx

Receiving end of the ASCII message link: consumes the 8-bit character stream produced by the message transmitter chip and recognises complete message frames. It aligns to frame boundaries, locks after consecutive good frames, and counts good frames and errors. It sits downstream of the transmitter's parallel byte bus and feeds status to the board-level monitor.

## Interface
- LOCK_FRAMES, default 2: consecutive complete frames required to assert `locked` (legal 1..15).
- CNT_W, default 16: width of `frame_cnt`.
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high.
- data_in  in  8  received character byte.
- data_valid  in  1  `data_in` is sampled only on edges where this is 1.
- select  in  2  expected message: 00/11 → message A, 01/10 → message B. Internally `msg_sel = select[1]^select[0]`.
- locked  out  1  receiver aligned and locked.
- frame_ok  out  1  one-cycle pulse: a complete frame was received correctly.
- frame_cnt  out  CNT_W  good frames since reset, saturating.
- err_pulse  out  1  one-cycle pulse: mismatch while locked.
- err_cnt  out  8  error events since reset, saturating at 255.
- char_idx  out  4  index of the next expected character.

## Operation
- Message A ("Guatemala", 9 bytes): 47 75 61 74 65 6D 61 6C 61.
- Message B (7 bytes): 51 51 75 65 74 7A 61.
- Let `last` be the final index of the selected message: 8 for A, 6 for B.
- Internal `good` counter, 0..LOCK_FRAMES.
- States:
  - HUNT: idx=0.
  - TRACK: aligned, not locked.
  - LOCKED.
- Each accepted byte (data_valid=1) is compared with msg[msg_sel][idx].
- HUNT:
  - Byte equals msg[0] → TRACK, idx=1.
  - Otherwise stay in HUNT.
- TRACK/LOCKED, match:
  - If idx<last: idx+1.
  - If idx==last: idx=0, pulse frame_ok, frame_cnt+1 (saturating).
  - If idx==last and state is TRACK: good+1. When good reaches LOCK_FRAMES → LOCKED.
- TRACK/LOCKED, mismatch (realign rule):
  - good=0.
  - If byte==msg[0] → TRACK, idx=1; otherwise → HUNT, idx=0.
  - From LOCKED only: additionally pulse err_pulse and increment err_cnt (saturating).
  - A mismatch in TRACK never raises an error.
- `locked` = (state==LOCKED).
- Select change: on an edge where msg_sel differs from its registered previous value:
  - Force HUNT, idx=0, good=0; the byte on that edge is ignored.
  - No err_pulse; counters are kept.
  - Switching 00↔11 or 01↔10 is not a change.
- data_valid=0: all state, idx and counters hold; pulses are 0.

## Timing
- All outputs are registered.
- frame_ok and err_pulse are high for exactly the one cycle following the edge that accepted the deciding byte.
- `locked` rises on the same edge as the frame_ok of the LOCK_FRAMES-th good frame.
- `locked` falls on the edge that accepts a mismatching byte or a select change.
- frame_ok and err_pulse are never high together.
- Reset values: locked=0, frame_ok=0, err_pulse=0, frame_cnt=0, err_cnt=0, char_idx=0; state=HUNT, good=0, previous msg_sel=0.
- Reset asserted mid-frame clears everything immediately (asynchronous).
- The first byte after reset release is evaluated in HUNT.
- Throughput: one byte per cycle, with no back-pressure.

## Structure
- Shared package `msg_link_pkg` holds:
  - The state enum (HUNT, TRACK, LOCKED).
  - Message length constants MSG_A_LEN=9 and MSG_B_LEN=7.
  - Both character tables as constants.
- The transmitter is updated to use the same package.
- One sub-module: `msg_char_rom`, combinational. Inputs msg_sel and idx; outputs the expected byte and an `is_last` flag.
- Everything else (FSM, idx, good, counters, select-change detect) lives in msg_stream_rx.

## Test plan
- Lock on A: reset, select=00, stream message A twice back-to-back.
  - frame_ok after bytes 9 and 18; locked=1 after byte 18; frame_cnt=2; err_cnt=0.
- Error when locked: while locked on A, replace byte 4 (0x74) with 0x00.
  - err_pulse for one cycle, err_cnt=1, locked=0, char_idx=0.
  - Two further clean frames → locked=1 again.
- Message B lock: select=01, stream 51 51 75 65 74 7A 61 repeatedly.
  - locked=1 after byte 14.
  - Changing select to 10 causes no resync and locked stays 1.
- Realign and gaps: in TRACK on A at idx=5, feed 0x47 → char_idx=1, no err_pulse.
  - Insert 3 data_valid=0 cycles mid-frame → char_idx and counters unchanged; the frame still completes with frame_ok.
- Select change while locked: switch 00→01 mid-frame.
  - Next cycle: locked=0, char_idx=0, err_pulse=0, err_cnt unchanged.
- Saturation and reset: force 260 locked-mismatch events → err_cnt=255.
  - Assert reset mid-frame → all outputs 0 asynchronously.
